// File: rtl/tt_lut_pkg.sv
// Shared types and limits for the truth-table LUT engine.
package tt_lut_pkg;

  localparam int N_IN_MAX = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SWEEP = 2'd2
  } state_t;

endpackage

// File: rtl/tt_lut_out_reg.sv
// Single-entry valid/ready result holding register; contents stay stable until taken.
module tt_lut_out_reg #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] din_vec,
  input  logic         din_bit,
  input  logic         res_ready,
  output logic         res_valid,
  output logic [W-1:0] res_in,
  output logic         res_out,
  output logic         slot_free
);

  // The slot can take a new entry this cycle if empty or being drained now.
  assign slot_free = !res_valid || res_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_in    <= '0;
      res_out   <= 1'b0;
    end else if (load) begin
      res_valid <= 1'b1;
      res_in    <= din_vec;
      res_out   <= din_bit;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tt_lut_engine.sv
// Truth-table engine: shadow-loaded table, single evaluations and full-table sweeps.
module tt_lut_engine
  import tt_lut_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic            cfg_bit,
  input  logic            cfg_last,
  input  logic            eval_valid,
  output logic            eval_ready,
  input  logic [N_IN-1:0] eval_in,
  input  logic            sweep_start,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [N_IN-1:0] res_in,
  output logic            res_out,
  output logic            busy,
  output logic            table_loaded,
  output logic            cfg_err
);

  localparam int            DEPTH    = 1 << N_IN;
  localparam logic [N_IN:0] ROWS     = (N_IN + 1)'(DEPTH);
  localparam logic [N_IN:0] LAST_ROW = (N_IN + 1)'(DEPTH - 1);

  state_t            state;
  logic [DEPTH-1:0]  shadow;
  logic [DEPTH-1:0]  active;
  logic [DEPTH-1:0]  shadow_wr;
  logic [N_IN:0]     cnt;
  logic [N_IN-1:0]   row;
  logic              slot_free;
  logic              cfg_fire;
  logic              eval_fire;
  logic              sweep_issue;
  logic              res_fire;
  logic              out_load;
  logic [N_IN-1:0]   out_vec;
  logic              out_bit;

  assign row         = cnt[N_IN-1:0];
  assign cfg_ready   = (state != SWEEP);
  assign eval_ready  = cfg_ready && slot_free;
  assign cfg_fire    = cfg_valid && cfg_ready;
  assign eval_fire   = eval_valid && eval_ready;
  assign sweep_issue = (state == SWEEP) && (cnt < ROWS) && slot_free;
  assign res_fire    = res_valid && res_ready;

  // Evaluations read the active table only, so a same-cycle commit is not yet visible.
  assign out_load = eval_fire || sweep_issue;
  assign out_vec  = (state == SWEEP) ? row : eval_in;
  assign out_bit  = active[out_vec];

  always_comb begin
    shadow_wr      = shadow;
    shadow_wr[row] = cfg_bit;
  end

  // NOTE: both tables are ordinary flops cleared by reset, so no partial load survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shadow       <= '0;
      active       <= '0;
      table_loaded <= 1'b0;
      cnt          <= '0;
      busy         <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_fire) begin
            if (cfg_last) begin
              cfg_err <= 1'b1;
              shadow  <= '0;
            end else begin
              shadow <= shadow_wr;
              cnt    <= (N_IN + 1)'(1);
              state  <= LOAD;
            end
          end else if (sweep_start && table_loaded) begin
            state <= SWEEP;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        LOAD: begin
          if (cfg_fire) begin
            if ((cnt == LAST_ROW) || cfg_last) begin
              state  <= IDLE;
              cnt    <= '0;
              shadow <= '0;
              if ((cnt == LAST_ROW) && cfg_last) begin
                active       <= shadow_wr;
                table_loaded <= 1'b1;
              end else begin
                cfg_err <= 1'b1;
              end
            end else begin
              shadow <= shadow_wr;
              cnt    <= cnt + 1'b1;
            end
          end
        end
        SWEEP: begin
          if (sweep_issue) cnt <= cnt + 1'b1;
          // All rows issued and the last one is being taken: sweep is done.
          if ((cnt == ROWS) && res_fire) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  tt_lut_out_reg #(.W(N_IN)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (out_load),
    .din_vec   (out_vec),
    .din_bit   (out_bit),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res_in    (res_in),
    .res_out   (res_out),
    .slot_free (slot_free)
  );

endmodule

// File: tb/tb_tt_lut_engine.sv
// Directed bench for tt_lut_engine: a 2-input instance and a 3-input instance.
module tb_tt_lut_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic       a_cfg_valid, a_cfg_bit, a_cfg_last, a_eval_valid, a_sweep_start, a_res_ready;
  logic [1:0] a_eval_in;
  logic       a_cfg_ready, a_eval_ready, a_res_valid, a_res_out, a_busy, a_table_loaded, a_cfg_err;
  logic [1:0] a_res_in;

  logic       b_cfg_valid, b_cfg_bit, b_cfg_last, b_eval_valid, b_sweep_start, b_res_ready;
  logic [2:0] b_eval_in;
  logic       b_cfg_ready, b_eval_ready, b_res_valid, b_res_out, b_busy, b_table_loaded, b_cfg_err;
  logic [2:0] b_res_in;

  tt_lut_engine #(.N_IN(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(a_cfg_valid), .cfg_ready(a_cfg_ready), .cfg_bit(a_cfg_bit), .cfg_last(a_cfg_last),
    .eval_valid(a_eval_valid), .eval_ready(a_eval_ready), .eval_in(a_eval_in),
    .sweep_start(a_sweep_start), .res_valid(a_res_valid), .res_ready(a_res_ready),
    .res_in(a_res_in), .res_out(a_res_out), .busy(a_busy),
    .table_loaded(a_table_loaded), .cfg_err(a_cfg_err)
  );

  tt_lut_engine #(.N_IN(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready), .cfg_bit(b_cfg_bit), .cfg_last(b_cfg_last),
    .eval_valid(b_eval_valid), .eval_ready(b_eval_ready), .eval_in(b_eval_in),
    .sweep_start(b_sweep_start), .res_valid(b_res_valid), .res_ready(b_res_ready),
    .res_in(b_res_in), .res_out(b_res_out), .busy(b_busy),
    .table_loaded(b_table_loaded), .cfg_err(b_cfg_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic b_cfg(input logic bitv, input logic last);
    b_cfg_valid = 1'b1;
    b_cfg_bit   = bitv;
    b_cfg_last  = last;
    @(negedge clk);
    b_cfg_valid = 1'b0;
    b_cfg_last  = 1'b0;
  endtask

  task automatic b_load(input logic [7:0] bits, input int nbeats, input int last_idx);
    for (int i = 0; i < nbeats; i++) b_cfg(bits[i], i == last_idx);
  endtask

  task automatic b_eval(input string tag, input logic [2:0] v, input logic e);
    b_eval_valid = 1'b1;
    b_eval_in    = v;
    b_res_ready  = 1'b1;
    @(negedge clk);
    b_eval_valid = 1'b0;
    check({tag, "_valid"}, 32'(b_res_valid), 1);
    check({tag, "_in"}, 32'(b_res_in), 32'(v));
    check({tag, "_out"}, 32'(b_res_out), 32'(e));
  endtask

  // Row k of each table is bit k.
  logic [3:0] a_tab = 4'b1110;
  logic [7:0] t1    = 8'b1010_0110;
  logic [7:0] t2    = 8'b0101_1001;
  int got;
  int cyc;

  initial begin
    {a_cfg_valid, a_cfg_bit, a_cfg_last, a_eval_valid, a_sweep_start} = '0;
    {b_cfg_valid, b_cfg_bit, b_cfg_last, b_eval_valid, b_sweep_start} = '0;
    a_eval_in = '0;
    b_eval_in = '0;
    a_res_ready = 1'b1;
    b_res_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_res_valid", 32'(b_res_valid), 0);
    check("rst_busy", 32'(b_busy), 0);
    check("rst_loaded", 32'(b_table_loaded), 0);
    check("rst_cfg_err", 32'(b_cfg_err), 0);
    check("rst_res_in", 32'(b_res_in), 0);
    check("rst_cfg_ready", 32'(b_cfg_ready), 1);
    check("rst_eval_ready", 32'(b_eval_ready), 1);
    check("rst_a_valid", 32'(a_res_valid), 0);
    check("rst_a_ready", 32'({a_cfg_ready, a_eval_ready}), 3);
    rst_n = 1'b1;
    @(negedge clk);

    // 2-input table 0,1,1,1 then back-to-back evals 0..3
    for (int i = 0; i < 4; i++) begin
      a_cfg_valid = 1'b1;
      a_cfg_bit   = a_tab[i];
      a_cfg_last  = (i == 3);
      @(negedge clk);
    end
    a_cfg_valid = 1'b0;
    a_cfg_last  = 1'b0;
    check("a_loaded", 32'(a_table_loaded), 1);
    check("a_cfg_err", 32'(a_cfg_err), 0);
    for (int v = 0; v < 4; v++) begin
      a_eval_valid = 1'b1;
      a_eval_in    = 2'(v);
      @(negedge clk);
      check("a_eval_valid", 32'(a_res_valid), 1);
      check("a_eval_in", 32'(a_res_in), 32'(v));
      check("a_eval_out", 32'(a_res_out), 32'(a_tab[v]));
    end
    a_eval_valid = 1'b0;
    check("a_busy", 32'(a_busy), 0);

    // Evaluation before any load reads zero
    b_eval("pre_load", 3'd5, 1'b0);

    b_load(t1, 8, 7);
    check("t1_loaded", 32'(b_table_loaded), 1);
    check("t1_cfg_err", 32'(b_cfg_err), 0);
    for (int v = 0; v < 8; v++) begin
      b_eval_valid = 1'b1;
      b_eval_in    = 3'(v);
      @(negedge clk);
      check("t1_b2b_valid", 32'(b_res_valid), 1);
      check("t1_b2b_in", 32'(b_res_in), 32'(v));
      check("t1_b2b_out", 32'(b_res_out), 32'(t1[v]));
    end
    b_eval_valid = 1'b0;

    // Early cfg_last on beat 5
    b_load(8'hFF, 5, 4);
    check("early_last_err", 32'(b_cfg_err), 1);
    @(negedge clk);
    check("early_last_pulse", 32'(b_cfg_err), 0);
    check("early_last_loaded", 32'(b_table_loaded), 1);
    b_eval("early_old5", 3'd5, 1'b1);
    b_eval("early_old3", 3'd3, 1'b0);

    // Missing cfg_last on the final row
    b_load(8'hFF, 8, -1);
    check("no_last_err", 32'(b_cfg_err), 1);
    b_eval("no_last_old3", 3'd3, 1'b0);

    // Reload with evaluations during LOAD and in the commit cycle
    for (int i = 0; i < 8; i++) begin
      b_cfg_valid  = 1'b1;
      b_cfg_bit    = t2[i];
      b_cfg_last   = (i == 7);
      b_eval_valid = (i == 4) || (i == 7);
      b_eval_in    = (i == 4) ? 3'd3 : 3'd5;
      @(negedge clk);
      if (i == 4) begin
        check("reload_eval3_in", 32'(b_res_in), 3);
        check("reload_eval3_old", 32'(b_res_out), 0);
      end
      if (i == 7) begin
        check("commit_eval5_in", 32'(b_res_in), 5);
        check("commit_eval5_old", 32'(b_res_out), 1);
        check("commit_loaded", 32'(b_table_loaded), 1);
      end
    end
    b_cfg_valid  = 1'b0;
    b_cfg_last   = 1'b0;
    b_eval_valid = 1'b0;
    b_eval("new3", 3'd3, 1'b1);
    b_eval("new5", 3'd5, 1'b0);

    // sweep_start together with cfg_valid: load wins
    b_cfg_valid   = 1'b1;
    b_cfg_bit     = t2[0];
    b_cfg_last    = 1'b0;
    b_sweep_start = 1'b1;
    @(negedge clk);
    b_sweep_start = 1'b0;
    check("prio_busy", 32'(b_busy), 0);
    check("prio_cfg_ready", 32'(b_cfg_ready), 1);
    for (int i = 1; i < 8; i++) b_cfg(t2[i], i == 7);
    check("prio_commit_err", 32'(b_cfg_err), 0);
    check("prio_busy_after", 32'(b_busy), 0);
    @(negedge clk);

    // Sweep with res_ready toggling every cycle
    b_res_ready   = 1'b0;
    b_sweep_start = 1'b1;
    @(negedge clk);
    b_sweep_start = 1'b0;
    check("sweep_busy", 32'(b_busy), 1);
    check("sweep_cfg_ready", 32'(b_cfg_ready), 0);
    check("sweep_eval_ready", 32'(b_eval_ready), 0);
    got = 0;
    cyc = 0;
    while (got < 8 && cyc < 64) begin
      b_res_ready = ~b_res_ready;
      if (b_res_valid) begin
        check("sweep_res_in", 32'(b_res_in), 32'(got));
        check("sweep_res_out", 32'(b_res_out), 32'(t2[got]));
        check("sweep_busy_during", 32'(b_busy), 1);
        if (b_res_ready) got++;
      end
      @(negedge clk);
      cyc++;
    end
    check("sweep_count", 32'(got), 8);
    check("sweep_busy_clear", 32'(b_busy), 0);
    check("sweep_valid_clear", 32'(b_res_valid), 0);
    b_res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("sweep_no_extra", 32'(b_res_valid), 0);
    end

    // Pending eval drains first, then reset mid-sweep at row 4
    b_res_ready   = 1'b0;
    b_eval_valid  = 1'b1;
    b_eval_in     = 3'd6;
    b_sweep_start = 1'b1;
    @(negedge clk);
    b_eval_valid  = 1'b0;
    b_sweep_start = 1'b0;
    check("pend_valid", 32'(b_res_valid), 1);
    check("pend_in", 32'(b_res_in), 6);
    check("pend_out", 32'(b_res_out), 1);
    check("pend_busy", 32'(b_busy), 1);
    b_res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rs_row_in", 32'(b_res_in), 32'(i));
    end
    check("rs_row4_valid", 32'(b_res_valid), 1);
    rst_n = 1'b0;
    #1;
    check("rs_res_valid", 32'(b_res_valid), 0);
    check("rs_busy", 32'(b_busy), 0);
    check("rs_loaded", 32'(b_table_loaded), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    b_eval("post_rst3", 3'd3, 1'b0);
    check("post_rst_loaded", 32'(b_table_loaded), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_lut_engine.md
TT_LUT_ENGINE -- requirements
Module: tt_lut_engine

Interface
REQ-001 Parameter N_IN, default 3, number of truth-table inputs, legal range 1..6.
REQ-002 Parameter DEPTH, fixed at 2**N_IN, number of truth-table rows; not user-overridable.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cfg_valid / cfg_ready  in / out  1 / 1  table-load handshake.
REQ-006 cfg_bit / cfg_last  in / in  1 / 1  table row value; cfg_last marks the final row.
REQ-007 eval_valid / eval_ready  in / out  1 / 1  single-evaluation request handshake.
REQ-008 eval_in  in  N_IN  input vector, bit 0 = in1.
REQ-009 sweep_start  in  1  one-cycle request to enumerate all rows.
REQ-010 res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-011 res_in / res_out  out / out  N_IN / 1  input vector evaluated and table output.
REQ-012 busy / table_loaded / cfg_err  out / out / out  1 / 1 / 1  sweep active; valid table present; one-cycle load-error pulse.

Function
REQ-013 The engine SHALL hold an active table and a shadow table, each DEPTH bits; row k is the output for input vector k.
REQ-014 States SHALL be IDLE, LOAD and SWEEP.
REQ-015 IDLE->LOAD on the first cfg_valid&&cfg_ready; that bit SHALL be written to shadow row 0.
REQ-016 cfg_ready SHALL be 1 in IDLE and LOAD and 0 in SWEEP.
REQ-017 Each accepted cfg beat SHALL write the next shadow row in the order 0,1,...,DEPTH-1.
REQ-018 cfg_last on row DEPTH-1 SHALL copy shadow to active, set table_loaded=1 and return to IDLE.
REQ-019 cfg_last before row DEPTH-1, or its absence on row DEPTH-1, SHALL pulse cfg_err for 1 cycle, discard the shadow, leave the active table and table_loaded unchanged, and return to IDLE.
REQ-020 Evaluations SHALL be accepted in IDLE and LOAD, and SHALL always use the active table.
REQ-021 An evaluation accepted in the same cycle as a commit SHALL use the pre-commit table.
REQ-022 eval_ready SHALL equal (state!=SWEEP) && (!res_valid || res_ready).
REQ-023 An accepted eval SHALL present res_valid=1 with res_in=eval_in and res_out=active[eval_in] on the next cycle (latency 1).
REQ-024 Back-to-back evals at full throughput SHALL be possible while res_ready=1.
REQ-025 res_valid, res_in and res_out SHALL hold stable until res_ready=1.
REQ-026 sweep_start SHALL be honoured only in IDLE with table_loaded=1 and no cfg_valid in the same cycle; otherwise it SHALL be ignored (cfg has priority).
REQ-027 SWEEP SHALL emit DEPTH results with res_in = 0..DEPTH-1 in order, advancing only on res_valid&&res_ready.
REQ-028 busy SHALL be 1 from the cycle after an accepted sweep_start until the cycle after the final result handshake, then return to IDLE.
REQ-029 A pending single-eval result SHALL complete before the first sweep result is presented.
REQ-030 The row counter SHALL be N_IN+1 bits so DEPTH-1 does not wrap to 0 before completion is detected.

Reset
REQ-031 Asserting rst_n=0 SHALL immediately force state IDLE, both tables to 0, table_loaded=0, res_valid=0, res_in=0, res_out=0, busy=0, cfg_err=0 and counters to 0.
REQ-032 Reset mid-LOAD or mid-SWEEP SHALL abandon the operation with no partial commit.
REQ-033 Evaluation before any load SHALL return res_out=0.

Structure
REQ-034 Package tt_lut_pkg SHALL hold the state enum and N_IN_MAX=6.
REQ-035 The result valid/ready holding register SHALL be a sub-module, tt_lut_out_reg.

Verification
REQ-036 N_IN=2, load 0,1,1,1 with cfg_last on beat 4, eval 0..3 -> res_out 0,1,1,1, table_loaded=1.
REQ-037 N_IN=3, cfg_last on beat 5 -> cfg_err pulse; previous table still answers eval_in=5.
REQ-038 Sweep with res_ready toggling 1/0 each cycle -> 8 results with res_in 0..7 in order, none lost or duplicated, busy clears after the 8th.
REQ-039 During reload, eval_in=3 -> old value; after commit, eval_in=3 -> new value.
REQ-040 rst_n low mid-sweep at row 4 -> res_valid=0, busy=0, table_loaded=0 in the same cycle.
REQ-041 sweep_start and cfg_valid in the same IDLE cycle -> LOAD entered, sweep ignored, busy stays 0.
